// File: rtl/mux_pipe_nto1_pkg.sv
// Shared definitions for mux_pipe_nto1: select-width rule, legal input-count bounds and skid buffer state encoding.
package mux_pipe_nto1_pkg;

    localparam int N_IN_MIN = 2;
    localparam int N_IN_MAX = 16;

    // The select port is never narrower than one bit, even for a 2-input mux.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Encoded as {skid_valid, main_valid}; 2'b10 cannot be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } buf_state_e;

endpackage

// File: rtl/mux_pipe_nto1_skid_buf.sv
// Two-entry (main + skid) register stage with valid/ready handshake and flush.
// Latency: 1 cycle from accept to out_vld_o when main is empty or draining.
// Backpressure: in_rdy_o is a direct flop bit (!skid_valid), no path from out_rdy_i.
module skid_buf
    import mux_pipe_nto1_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [DW-1:0] in_dat_i,
    input  logic          in_vld_i,
    output logic          in_rdy_o,
    input  logic          flush_i,
    output logic [DW-1:0] out_dat_o,
    output logic          out_vld_o,
    input  logic          out_rdy_i
);

    buf_state_e    state_q;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            // Payload registers are left untouched; only the valid bits drop.
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_vld_i) begin
                        main_q  <= in_dat_i;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    case ({in_vld_i, out_rdy_i})
                        2'b10: begin
                            skid_q  <= in_dat_i;
                            state_q <= TWO;
                        end
                        2'b01:   state_q <= EMPTY;
                        2'b11:   main_q  <= in_dat_i;
                        default: state_q <= ONE;
                    endcase
                end
                TWO: begin
                    if (out_rdy_i) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign out_dat_o = main_q;
    assign out_vld_o = state_q[0];
    assign in_rdy_o  = ~state_q[1];

endmodule

// File: rtl/mux_pipe_nto1.sv
// N_IN-to-1 select mux registered behind a 2-entry skid buffer; sel >= N_IN picks the last input.
// Latency: 1 cycle accept-to-output; full throughput with out_ready held high.
// Backpressure: in_ready drops once both entries hold beats. Optional MUX_PIPE_SEL_ERR_EN adds out_sel_err.
module mux_pipe_nto1
    import mux_pipe_nto1_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 3,
    parameter int SEL_W = sel_width(N_IN)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MUX_PIPE_SEL_ERR_EN
    ,
    output logic                  out_sel_err
`endif
);

    logic [WIDTH-1:0] sel_dat;

    // Default to the last input so out-of-range selects fall through to it.
    always_comb begin
        sel_dat = in_data[(N_IN-1)*WIDTH +: WIDTH];
        for (int k = 0; k < N_IN - 1; k++) begin
            if (int'(sel) == k) begin
                sel_dat = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_PIPE_SEL_ERR_EN
    localparam int DW = WIDTH + SEL_W + 1;
    logic sel_err;
    assign sel_err = (int'(sel) >= N_IN);
`else
    localparam int DW = WIDTH + SEL_W;
`endif

    logic [DW-1:0] in_pay;
    logic [DW-1:0] out_pay;

`ifdef MUX_PIPE_SEL_ERR_EN
    assign in_pay = {sel_err, sel, sel_dat};
    assign {out_sel_err, out_sel, out_data} = out_pay;
`else
    assign in_pay = {sel, sel_dat};
    assign {out_sel, out_data} = out_pay;
`endif

    skid_buf #(
        .DW(DW)
    ) u_skid_buf (
        .clk_i    (Clk),
        .rst_ni   (Rst),
        .in_dat_i (in_pay),
        .in_vld_i (in_valid),
        .in_rdy_o (in_ready),
        .flush_i  (flush),
        .out_dat_o(out_pay),
        .out_vld_o(out_valid),
        .out_rdy_i(out_ready)
    );

endmodule

// File: tb/tb_mux_pipe_nto1.sv
// Directed, table-driven bench for mux_pipe_nto1 (default 3x32 build plus 2x8 and 16x64 builds).
module tb_mux_pipe_nto1;

    localparam logic [31:0] A = 32'h11111111;
    localparam logic [31:0] B = 32'h22222222;
    localparam logic [31:0] C = 32'h33333333;

    logic        Clk;
    logic        Rst;
    logic        flush;

    logic [95:0] in_data;
    logic [1:0]  sel;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_sel;

    logic [15:0] in2;
    logic        sel2, vld2, rdy2, ovld2;
    logic [7:0]  out2;
    logic        osel2;

    logic [1023:0] in16;
    logic [3:0]  sel16, osel16;
    logic        vld16, rdy16, ovld16;
    logic [63:0] out16;

`ifdef MUX_PIPE_SEL_ERR_EN
    logic err3, err2, err16;
`endif

    int total = 0;
    int bad   = 0;

    mux_pipe_nto1 #(.WIDTH(32), .N_IN(3)) dut (
        .Clk(Clk), .Rst(Rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_PIPE_SEL_ERR_EN
        , .out_sel_err(err3)
`endif
    );

    mux_pipe_nto1 #(.WIDTH(8), .N_IN(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .in_data(in2), .sel(sel2), .in_valid(vld2),
        .in_ready(rdy2), .flush(flush), .out_data(out2), .out_sel(osel2),
        .out_valid(ovld2), .out_ready(1'b1)
`ifdef MUX_PIPE_SEL_ERR_EN
        , .out_sel_err(err2)
`endif
    );

    mux_pipe_nto1 #(.WIDTH(64), .N_IN(16)) dut16 (
        .Clk(Clk), .Rst(Rst), .in_data(in16), .sel(sel16), .in_valid(vld16),
        .in_ready(rdy16), .flush(flush), .out_data(out16), .out_sel(osel16),
        .out_valid(ovld16), .out_ready(1'b1)
`ifdef MUX_PIPE_SEL_ERR_EN
        , .out_sel_err(err16)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // The {skid_valid, main_valid} = 10 state shows up on the ports as in_ready=0 with out_valid=0.
    always @(negedge Clk) begin
        if (Rst) begin
            total++;
            if (!in_ready && !out_valid) begin
                bad++;
                $display("FAIL state10: in_ready=%0b out_valid=%0b (illegal combination)", in_ready, out_valid);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{2'd0, A, 1'b0};
        vecs[1] = '{2'd1, B, 1'b0};
        vecs[2] = '{2'd2, C, 1'b0};
        vecs[3] = '{2'd3, C, 1'b1};

        Rst = 1'b0; flush = 1'b0;
        in_data = {C, B, A}; sel = '0; in_valid = 1'b0; out_ready = 1'b1;
        in2 = {8'hB2, 8'hA1}; sel2 = 1'b0; vld2 = 1'b0;
        vld16 = 1'b0; sel16 = '0;
        for (int k = 0; k < 16; k++) in16[k*64 +: 64] = {32'(k), 32'hC0DE0000 | 32'(k)};

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sel", 64'(out_sel), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge Clk);
        Rst = 1'b1;
        tick();

        // Select table, back-to-back with out_ready high.
        for (int i = 0; i < 4; i++) begin
            sel = vecs[i].sel; in_valid = 1'b1;
            chk("tbl_in_ready", 64'(in_ready), 64'd1);
            tick();
            chk("tbl_out_valid", 64'(out_valid), 64'd1);
            chk("tbl_out_data", 64'(out_data), 64'(vecs[i].exp_dat));
            chk("tbl_out_sel", 64'(out_sel), 64'(vecs[i].sel));
`ifdef MUX_PIPE_SEL_ERR_EN
            chk("tbl_sel_err", 64'(err3), 64'(vecs[i].exp_err));
`endif
        end

        // Streaming: 8 distinct beats on consecutive cycles.
        sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            in_data[31:0] = 32'h100 + 32'(i);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            tick();
            chk("stream_out_valid", 64'(out_valid), 64'd1);
            chk("stream_out_data", 64'(out_data), 64'h100 + 64'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 64'(out_valid), 64'd0);

        // Backpressure: D1, D2 accepted, D3 held off until skid frees.
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
        in_data[63:32] = 32'hD1; tick();
        chk("bp_ready_after1", 64'(in_ready), 64'd1);
        in_data[63:32] = 32'hD2; tick();
        chk("bp_ready_after2", 64'(in_ready), 64'd0);
        chk("bp_hold_d1", 64'(out_data), 64'hD1);
        in_data[63:32] = 32'hD3; tick();
        chk("bp_still_full", 64'(in_ready), 64'd0);
        chk("bp_stable_data", 64'(out_data), 64'hD1);
        chk("bp_stable_sel", 64'(out_sel), 64'd1);
        out_ready = 1'b1; tick();
        chk("bp_out_d2", 64'(out_data), 64'hD2);
        chk("bp_ready_again", 64'(in_ready), 64'd1);
        tick();
        chk("bp_out_d3", 64'(out_data), 64'hD3);
        chk("bp_out_d3_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0; tick();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush from TWO with a concurrent in_valid.
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd2;
        in_data[95:64] = 32'hE1; tick();
        in_data[95:64] = 32'hE2; tick();
        chk("fl_two_reached", 64'(in_ready), 64'd0);
        flush = 1'b1; in_data[95:64] = 32'hE9; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1; tick();
        chk("fl_no_ghost", 64'(out_valid), 64'd0);

        // Flush from ONE: an accept in the flush cycle is dropped and main data is kept.
        out_ready = 1'b0; in_valid = 1'b1; in_data[95:64] = 32'hF1; tick();
        flush = 1'b1; in_data[95:64] = 32'hF2; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1_out_valid", 64'(out_valid), 64'd0);
        chk("fl1_data_kept", 64'(out_data), 64'hF1);
        out_ready = 1'b1; tick();
        chk("fl1_no_ghost", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-cycle while in ONE.
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1; in_data[63:32] = 32'hAB; tick();
        in_valid = 1'b0;
        chk("ar_in_one", 64'(out_valid), 64'd1);
        #2 Rst = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_out_data", 64'(out_data), 64'd0);
        chk("ar_out_sel", 64'(out_sel), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        @(negedge Clk);
        Rst = 1'b1;
        tick();
        out_ready = 1'b1; in_valid = 1'b1; sel = 2'd0; in_data[31:0] = 32'h5A5A; tick();
        in_valid = 1'b0;
        chk("ar_first_valid", 64'(out_valid), 64'd1);
        chk("ar_first_data", 64'(out_data), 64'h5A5A);
        tick();

        // Select sweeps on the 2x8 and 16x64 builds.
        for (int s = 0; s < 16; s++) begin
            sel16 = 4'(s); vld16 = 1'b1;
            vld2 = (s < 2); sel2 = s[0];
            tick();
            chk("n16_valid", 64'(ovld16), 64'd1);
            chk("n16_data", out16, {32'(s), 32'hC0DE0000 | 32'(s)});
            chk("n16_sel", 64'(osel16), 64'(s));
`ifdef MUX_PIPE_SEL_ERR_EN
            chk("n16_sel_err", 64'(err16), 64'd0);
`endif
            if (s < 2) begin
                chk("n2_valid", 64'(ovld2), 64'd1);
                chk("n2_data", 64'(out2), (s == 0) ? 64'hA1 : 64'hB2);
                chk("n2_sel", 64'(osel2), 64'(s));
`ifdef MUX_PIPE_SEL_ERR_EN
                chk("n2_sel_err", 64'(err2), 64'd0);
`endif
            end
        end
        vld16 = 1'b0; vld2 = 1'b0;
        tick();
        chk("n2_rdy", 64'(rdy2), 64'd1);
        chk("n16_rdy", 64'(rdy16), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_pipe_nto1.md
Name: mux_pipe_nto1

Overview:
- Parametrised, registered successor to the fixed 3-to-1 32-bit select mux used in the datapath (forwarding, ALU source, writeback select).
- Selects one of N_IN WIDTH-bit inputs and registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Gives full throughput under stalls, adds a pipeline flush, and keeps the legacy rule: an out-of-range select picks the last input.
- Sits between pipeline stages in place of a combinational mux plus a separate stage register.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_IN, 3, number of inputs (legal 2..16).
- SEL_W, $clog2(N_IN) (minimum 1), width of the select port. Derived; do not override.

Ports:
- Clk  in  1  clock, all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- in_data  in  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  input select, sampled with in_data.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  block can accept a beat this cycle.
- flush  in  1  drop all buffered beats.
- out_data  out  WIDTH  selected, registered data.
- out_sel  out  SEL_W  select value captured with out_data.
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  downstream accepts a beat.

Behaviour:
- Accept: the beat is taken on a rising edge with in_valid && in_ready. Transfer out: on a rising edge with out_valid && out_ready.
- Select: sel = k with k < N_IN picks input k. sel >= N_IN picks input N_IN-1 (legacy default branch). Selection is evaluated at accept time, not at output.
- Latency: 1 cycle from accept to out_valid when the output register is empty, or is draining in the same cycle.
- Storage: output register (main) plus one skid register.
  - in_ready = !skid_valid, driven from a flop with no combinational path from out_ready.
  - Accept while main is full and not draining: the beat goes to skid.
  - Main drains while skid is full: skid moves to main, skid empties.
  - Accept and drain in the same cycle with skid empty: the new beat goes to main.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (00): accept -> ONE.
  - ONE (01): accept without drain -> TWO. Drain without accept -> EMPTY. Both -> ONE.
  - TWO (11): drain -> ONE. in_ready = 0, so no accept.
  - State 10 is unreachable. The verification engineer asserts this.
- Ordering: strictly FIFO. No beat is dropped or duplicated except by flush.
- Flush: at the rising edge where flush = 1, main_valid and skid_valid clear to 0 and any simultaneous accept is discarded. Flush has priority over accept and drain. Data and sel registers keep their values. in_ready is 1 in the following cycle.
- Output stability: while out_valid && !out_ready, out_data and out_sel hold stable.
- Reset: asynchronous assert, synchronous deassert handled externally. Reset values: out_data = 0, out_sel = 0, out_valid = 0, skid contents = 0, skid_valid = 0, in_ready = 1. Reset mid-transfer discards all beats.
- Width: no arithmetic on data. Each input is a fixed WIDTH-bit slice.

Optional Feature:
- Macro: MUX_PIPE_SEL_ERR_EN.
- Defined: adds output port out_sel_err (1 bit). It is 1 when the beat in main was accepted with sel >= N_IN. The flag travels with its beat through the skid path, resets to 0, and is left unchanged by flush.
- Undefined: the port is absent and no error flops are built. Out-of-range select still maps to input N_IN-1.

Decomposition:
- Shared header mux_defs.vh:
  - clog2 helper macro and the SEL_W minimum-1 rule.
  - Legal N_IN bounds.
  - Macro for packed-slice indexing.
- Sub-module skid_buf:
  - Parameter DW (payload = WIDTH + SEL_W, +1 when the error flag is enabled).
  - Holds the main/skid registers, valid bits, flush and handshake logic.
  - mux_pipe_nto1 = combinational select + skid_buf.

Test Plan:
- N_IN=3, WIDTH=32, inputs {A=0x11111111, B=0x22222222, C=0x33333333}. Apply sel = 0, 1, 2, 3 with out_ready held 1 -> out_data = A, B, C, C each 1 cycle after accept. out_sel = 0, 1, 2, 3. With MUX_PIPE_SEL_ERR_EN defined, out_sel_err = 1 only on the sel = 3 beat.
- Streaming with out_ready=1: 8 back-to-back beats -> in_ready stays 1, 8 outputs on 8 consecutive cycles, in order.
- Backpressure: out_ready=0, send 3 beats -> first 2 accepted, in_ready = 0 from the cycle after the 2nd accept. out_data holds beat 1. Raise out_ready -> beats 1, 2, 3 delivered in order, none lost.
- Flush: with the TWO state reached, assert flush together with in_valid for 1 cycle -> next cycle out_valid = 0, in_ready = 1, and the concurrent beat does not appear.
- Asynchronous reset: assert Rst low mid-cycle while in ONE -> out_valid = 0 and out_data = 0 immediately, with no Clk edge needed. After release, the first accepted beat appears with 1-cycle latency.
- N_IN=2 / WIDTH=8 and N_IN=16 / WIDTH=64 builds: sel sweep 0..2^SEL_W-1 -> correct slice, with out-of-range values mapping to input N_IN-1.
